// File: rtl/m_line_counter.sv
// ---------------------------------------------------------------------------
// m_line_counter
//
// Purpose
//   9-bit programmable line counter. Q counts up while CE is high and wraps
//   to 0 after reaching the programmable terminal value TERM, producing a
//   one-cycle TC pulse after each such terminal wrap. An optional compare
//   register CMP latches an interrupt flag IRQ whenever Q moves onto the
//   compare value; ACK clears the flag.
//
// Configuration
//   LINE_COUNTER_IRQ_EN : when defined, the CMP register, IRQ flag and ACK
//                         input are active. When undefined, no CMP register
//                         is built, IRQ is tied low, writes with SEL=1 are
//                         dropped and ACK is ignored.
//
// Ports
//   MasterClock  in   1  sole clock, rising-edge
//   RESETL       in   1  asynchronous active-low reset
//   CE           in   1  count enable
//   CLR          in   1  synchronous counter clear (priority over CE)
//   WR           in   1  register write strobe
//   SEL          in   1  write target: 0 = TERM, 1 = CMP
//   D            in   9  write data
//   ACK          in   1  interrupt acknowledge
//   Q            out  9  registered counter value
//   TC           out  1  registered terminal-count pulse
//   IRQ          out  1  registered compare-match flag
// ---------------------------------------------------------------------------
module m_line_counter (
    input  logic       MasterClock,
    input  logic       RESETL,
    input  logic       CE,
    input  logic       CLR,
    input  logic       WR,
    input  logic       SEL,
    input  logic [8:0] D,
    input  logic       ACK,
    output logic [8:0] Q,
    output logic       TC,
    output logic       IRQ
);

    localparam logic [8:0] TERM_RESET = 9'd311;

    logic [8:0] r_q;
    logic       r_tc;
    logic [8:0] r_term;

    logic       w_at_term;
    logic       w_term_wrap;
    logic [8:0] w_q_next;

    // Terminal test always uses the TERM value held before the edge, so a
    // write landing on the same edge only affects the following cycles.
    assign w_at_term   = (r_q == r_term);
    assign w_term_wrap = CE && !CLR && w_at_term;

    // Next counter value. CLR wins over CE. When TERM has been written below
    // the current count, Q simply runs on and the 9-bit add wraps 511 -> 0
    // without a terminal pulse.
    always_comb begin
        w_q_next = r_q;
        if (CLR) begin
            w_q_next = 9'd0;
        end else if (CE) begin
            if (w_at_term) begin
                w_q_next = 9'd0;
            end else begin
                w_q_next = r_q + 9'd1;
            end
        end
    end

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_q  <= 9'd0;
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_q_next;
            r_tc <= w_term_wrap;
        end
    end

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_term <= TERM_RESET;
        end else if (WR && !SEL) begin
            r_term <= D;
        end
    end

    assign Q  = r_q;
    assign TC = r_tc;

`ifdef LINE_COUNTER_IRQ_EN

    localparam logic [8:0] CMP_RESET = 9'd511;

    logic [8:0] r_cmp;
    logic       r_irq;
    logic       w_irq_set;

    // A clear only counts as reaching the compare value when CMP is 0.
    // A count or wrap sets the flag when the new value equals CMP; holding
    // Q with CE low never sets it, so a parked counter cannot retrigger.
    always_comb begin
        w_irq_set = 1'b0;
        if (CLR) begin
            w_irq_set = (r_cmp == 9'd0);
        end else if (CE) begin
            w_irq_set = (w_q_next == r_cmp);
        end
    end

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_cmp <= CMP_RESET;
        end else if (WR && SEL) begin
            r_cmp <= D;
        end
    end

    // Set has priority over acknowledge on the same edge.
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_set || (r_irq && !ACK);
        end
    end

    assign IRQ = r_irq;

`else

    logic w_unused_ack;

    assign w_unused_ack = ACK;
    assign IRQ          = 1'b0;

`endif

endmodule

// File: tb/tb_m_line_counter.sv
// ---------------------------------------------------------------------------
// tb_m_line_counter
//
// Self-checking bench for m_line_counter. A behavioural model (plain integer
// arithmetic on Q, TERM, CMP, TC and IRQ) is advanced once per clock edge and
// directed scenarios additionally check against hand-derived constants.
// Honours LINE_COUNTER_IRQ_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_m_line_counter;

`ifdef LINE_COUNTER_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic       MasterClock = 1'b0;
    logic       RESETL      = 1'b0;
    logic       CE          = 1'b0;
    logic       CLR         = 1'b0;
    logic       WR          = 1'b0;
    logic       SEL         = 1'b0;
    logic [8:0] D           = 9'd0;
    logic       ACK         = 1'b0;
    logic [8:0] Q;
    logic       TC;
    logic       IRQ;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int mq;
    int mterm;
    int mcmp;
    bit mtc;
    bit mirq;

    m_line_counter dut (
        .MasterClock (MasterClock),
        .RESETL      (RESETL),
        .CE          (CE),
        .CLR         (CLR),
        .WR          (WR),
        .SEL         (SEL),
        .D           (D),
        .ACK         (ACK),
        .Q           (Q),
        .TC          (TC),
        .IRQ         (IRQ)
    );

    always #5 MasterClock = ~MasterClock;

    task automatic model_reset();
        mq    = 0;
        mterm = 311;
        mcmp  = 511;
        mtc   = 1'b0;
        mirq  = 1'b0;
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model from
    // the pre-edge register values, then return 1 time unit after the edge.
    task automatic tick(input bit ce, input bit clr, input bit wr,
                        input bit sel, input int d, input bit ack);
        int nq;
        bit set;
        CE  = ce;
        CLR = clr;
        WR  = wr;
        SEL = sel;
        D   = d[8:0];
        ACK = ack;
        @(posedge MasterClock);
        set = 1'b0;
        if (clr) begin
            nq  = 0;
            mtc = 1'b0;
            set = (mcmp == 0);
        end else if (ce) begin
            if (mq == mterm) begin
                nq  = 0;
                mtc = 1'b1;
            end else begin
                nq  = (mq + 1) % 512;
                mtc = 1'b0;
            end
            set = (nq == mcmp);
        end else begin
            nq  = mq;
            mtc = 1'b0;
        end
        if (IRQ_BUILT) mirq = set || (mirq && !ack);
        else           mirq = 1'b0;
        if (wr) begin
            if (!sel)           mterm = d % 512;
            else if (IRQ_BUILT) mcmp  = d % 512;
        end
        mq = nq;
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (Q !== 9'd0 || TC !== 1'b0 || IRQ !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: Q=%0d TC=%b IRQ=%b expected 0/0/0", Q, TC, IRQ);
        end
        @(posedge MasterClock);
        #1;
        checks++;
        if (Q !== 9'd0 || TC !== 1'b0 || IRQ !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: Q=%0d TC=%b IRQ=%b expected 0/0/0", Q, TC, IRQ);
        end
        @(negedge MasterClock);
        RESETL = 1'b1;
        model_reset();
    endtask

    task automatic test_full_count();
        int tcCount;
        int expQ;
        tcCount = 0;
        for (int i = 1; i <= 312; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            expQ = (i == 312) ? 0 : i;
            if (TC === 1'b1) tcCount++;
            checks++;
            if (Q !== expQ[8:0] || TC !== (i == 312)) begin
                errors++;
                $display("[TB] FAIL full_count step %0d: Q=%0d TC=%b expected Q=%0d TC=%b",
                         i, Q, TC, expQ, (i == 312));
            end
        end
        tick(1, 0, 0, 0, 0, 0);
        if (TC === 1'b1) tcCount++;
        checks++;
        if (Q !== 9'd1 || tcCount != 1) begin
            errors++;
            $display("[TB] FAIL full_count_after: Q=%0d tcPulses=%0d expected Q=1 tcPulses=1", Q, tcCount);
        end
    endtask

    task automatic test_term_four();
        int expSeq[7] = '{0, 1, 2, 3, 4, 0, 1};
        tick(0, 1, 1, 0, 4, 0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick(1, 0, 0, 0, 0, 0);
            checks++;
            if (Q !== expSeq[i][8:0] || TC !== (i == 5) || Q !== mq[8:0]) begin
                errors++;
                $display("[TB] FAIL term_four step %0d: Q=%0d TC=%b expected Q=%0d TC=%b",
                         i, Q, TC, expSeq[i], (i == 5));
            end
        end
    endtask

    task automatic test_wr_at_term();
        tick(0, 1, 1, 0, 311, 0);
        for (int i = 0; i < 311; i++) tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (Q !== 9'd311 || TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_at_term_pre: Q=%0d TC=%b expected Q=311 TC=0", Q, TC);
        end
        tick(1, 0, 1, 0, 5, 0);
        checks++;
        if (Q !== 9'd0 || TC !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_at_term_wrap: Q=%0d TC=%b expected Q=0 TC=1", Q, TC);
        end
        for (int i = 1; i <= 5; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            checks++;
            if (Q !== i[8:0] || TC !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wr_at_term_run %0d: Q=%0d TC=%b expected Q=%0d TC=0", i, Q, TC, i);
            end
        end
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (Q !== 9'd0 || TC !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_at_term_newwrap: Q=%0d TC=%b expected Q=0 TC=1", Q, TC);
        end
    endtask

    task automatic test_term_below();
        int tcCount;
        int expQ;
        tcCount = 0;
        tick(0, 1, 1, 0, 311, 0);
        for (int i = 0; i < 100; i++) tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 50, 0);
        checks++;
        if (Q !== 9'd100 || TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL term_below_load: Q=%0d TC=%b expected Q=100 TC=0", Q, TC);
        end
        for (int i = 1; i <= 412; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            if (TC === 1'b1) tcCount++;
            expQ = (100 + i) % 512;
            checks++;
            if (Q !== expQ[8:0]) begin
                errors++;
                $display("[TB] FAIL term_below_run %0d: Q=%0d expected %0d", i, Q, expQ);
            end
        end
        checks++;
        if (tcCount != 0) begin
            errors++;
            $display("[TB] FAIL term_below_notc: tcPulses=%0d expected 0", tcCount);
        end
        for (int i = 1; i <= 50; i++) tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (Q !== 9'd50 || TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL term_below_at50: Q=%0d TC=%b expected Q=50 TC=0", Q, TC);
        end
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (Q !== 9'd0 || TC !== 1'b1) begin
            errors++;
            $display("[TB] FAIL term_below_wrap: Q=%0d TC=%b expected Q=0 TC=1", Q, TC);
        end
    endtask

    task automatic test_irq();
        tick(0, 1, 1, 1, 10, 1);
        checks++;
        if (IRQ !== 1'b0 || Q !== 9'd0) begin
            errors++;
            $display("[TB] FAIL irq_setup: IRQ=%b Q=%0d expected IRQ=0 Q=0", IRQ, Q);
        end
        for (int i = 1; i <= 9; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("[TB] FAIL irq_early %0d: IRQ=%b expected 0", i, IRQ);
            end
        end
        tick(1, 0, 0, 0, 0, 1);
        checks++;
        if (Q !== 9'd10 || IRQ !== IRQ_BUILT) begin
            errors++;
            $display("[TB] FAIL irq_set_with_ack: Q=%0d IRQ=%b expected Q=10 IRQ=%b", Q, IRQ, IRQ_BUILT);
        end
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (IRQ !== IRQ_BUILT) begin
            errors++;
            $display("[TB] FAIL irq_held: IRQ=%b expected %b", IRQ, IRQ_BUILT);
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_ack_clear: IRQ=%b expected 0", IRQ);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            checks++;
            if (IRQ !== 1'b0 || Q !== 9'd10) begin
                errors++;
                $display("[TB] FAIL irq_no_retrigger %0d: IRQ=%b Q=%0d expected IRQ=0 Q=10", i, IRQ, Q);
            end
        end
        tick(0, 0, 1, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        checks++;
        if (IRQ !== IRQ_BUILT || Q !== 9'd0) begin
            errors++;
            $display("[TB] FAIL irq_clr_cmp0: IRQ=%b Q=%0d expected IRQ=%b Q=0", IRQ, Q, IRQ_BUILT);
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (IRQ !== 1'b0 || IRQ !== mirq) begin
            errors++;
            $display("[TB] FAIL irq_final_ack: IRQ=%b expected 0", IRQ);
        end
    endtask

    task automatic test_reset_midcount();
        tick(0, 1, 1, 0, 400, 1);
        tick(0, 0, 1, 1, 150, 0);
        for (int i = 0; i < 200; i++) tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (Q !== 9'd200 || IRQ !== IRQ_BUILT) begin
            errors++;
            $display("[TB] FAIL midcount_pre: Q=%0d IRQ=%b expected Q=200 IRQ=%b", Q, IRQ, IRQ_BUILT);
        end
        #3;
        RESETL = 1'b0;
        #1;
        checks++;
        if (Q !== 9'd0 || TC !== 1'b0 || IRQ !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midcount_async: Q=%0d TC=%b IRQ=%b expected 0/0/0", Q, TC, IRQ);
        end
        @(posedge MasterClock);
        #1;
        checks++;
        if (Q !== 9'd0 || TC !== 1'b0 || IRQ !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midcount_hold: Q=%0d TC=%b IRQ=%b expected 0/0/0", Q, TC, IRQ);
        end
        @(negedge MasterClock);
        RESETL = 1'b1;
        model_reset();
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (Q !== 9'd1 || TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midcount_first_edge: Q=%0d TC=%b expected Q=1 TC=0", Q, TC);
        end
        for (int i = 2; i <= 312; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            checks++;
            if (TC !== (i == 312) || IRQ !== 1'b0 || Q !== ((i == 312) ? 9'd0 : i[8:0])) begin
                errors++;
                $display("[TB] FAIL midcount_term311 %0d: Q=%0d TC=%b IRQ=%b expected Q=%0d TC=%b IRQ=0",
                         i, Q, TC, IRQ, (i == 312) ? 0 : i, (i == 312));
            end
        end
    endtask

    task automatic test_random();
        bit ce, clr, wr, sel, ack;
        int d;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                #3;
                RESETL = 1'b0;
                model_reset();
                #1;
                checks++;
                if (Q !== 9'd0 || TC !== 1'b0 || IRQ !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL random_reset %0d: Q=%0d TC=%b IRQ=%b expected 0/0/0", n, Q, TC, IRQ);
                end
                @(negedge MasterClock);
                RESETL = 1'b1;
            end
            ce  = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 99) < 3);
            wr  = ($urandom_range(0, 99) < 5);
            sel = $urandom_range(0, 1);
            ack = ($urandom_range(0, 9) < 2);
            d   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 511);
            tick(ce, clr, wr, sel, d, ack);
            checks++;
            if (Q !== mq[8:0] || TC !== mtc || IRQ !== mirq) begin
                errors++;
                $display("[TB] FAIL random %0d: Q=%0d TC=%b IRQ=%b expected Q=%0d TC=%b IRQ=%b",
                         n, Q, TC, IRQ, mq, mtc, mirq);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_count();
        test_term_four();
        test_wr_at_term();
        test_term_below();
        test_irq();
        test_reset_midcount();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
